// File: rtl/speaker_pkg.sv
// Shared types and constants for the note/tone synthesis path.
package speaker_pkg;

  localparam int NOTES_PER_OCTAVE = 12;
  localparam int NOTE_W           = 4;
  localparam int OCT_W            = 3;
  localparam int DIV_W            = 9;
  localparam int OCT_CNT_W        = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Half-period divider per note-in-octave; anything past 11 is a rest and never toggles.
  function automatic logic [DIV_W-1:0] note_div(input logic [NOTE_W-1:0] n);
    logic [DIV_W-1:0] d;
    case (n)
      4'd0:    d = 9'd511;
      4'd1:    d = 9'd482;
      4'd2:    d = 9'd455;
      4'd3:    d = 9'd430;
      4'd4:    d = 9'd405;
      4'd5:    d = 9'd383;
      4'd6:    d = 9'd361;
      4'd7:    d = 9'd341;
      4'd8:    d = 9'd322;
      4'd9:    d = 9'd303;
      4'd10:   d = 9'd286;
      4'd11:   d = 9'd270;
      default: d = 9'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Down-counter that pulses tick for one cycle each time it wraps through zero.
module tick_prescaler #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Load restarts a full tick period; otherwise count down and reload at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/note_tone_player.sv
// Plays one note (or rest) as a square wave for a number of duration ticks.
module note_tone_player
  import speaker_pkg::*;
#(
  parameter int TICK_DIV = 25000,
  parameter int DUR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OCT_W-1:0]     octave,
  input  logic [NOTE_W-1:0]    note,
  input  logic [DUR_W-1:0]     duration,
  output logic                 busy,
  output logic                 done,
  output logic                 speaker
);

  state_t                 state;
  logic [DIV_W-1:0]       note_cnt;
  logic [DIV_W-1:0]       note_rld;
  logic [OCT_CNT_W-1:0]   oct_cnt;
  logic [OCT_CNT_W-1:0]   oct_rld;
  logic [DUR_W-1:0]       dur_cnt;
  logic                   rest;
  logic                   accept;
  logic                   tick;

  // A zero-length request never enters PLAY, so it must not restart the prescaler.
  assign accept = (state == IDLE) && start && (duration != '0);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (state == PLAY),
    .tick  (tick)
  );

  // Sequencing FSM: latch the request, divide down to the tone, count duration ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      speaker  <= 1'b0;
      note_cnt <= '0;
      note_rld <= '0;
      oct_cnt  <= '0;
      oct_rld  <= '0;
      dur_cnt  <= '0;
      rest     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          speaker <= 1'b0;
          if (start) begin
            if (duration != '0) begin
              state    <= PLAY;
              busy     <= 1'b1;
              note_rld <= note_div(note);
              note_cnt <= note_div(note);
              oct_rld  <= 8'hFF >> octave;
              oct_cnt  <= 8'hFF >> octave;
              rest     <= (note >= NOTE_W'(NOTES_PER_OCTAVE));
              dur_cnt  <= duration;
            end else begin
              done <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (note_cnt == '0) begin
            note_cnt <= note_rld;
            if (oct_cnt == '0) begin
              oct_cnt <= oct_rld;
              if (!rest) speaker <= ~speaker;
            end else begin
              oct_cnt <= oct_cnt - 1'b1;
            end
          end else begin
            note_cnt <= note_cnt - 1'b1;
          end
          // The final tick wins over any coincident toggle so the pin always parks low.
          if (tick) begin
            if (dur_cnt == DUR_W'(1)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              speaker <= 1'b0;
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_player.sv
// Directed bench for note_tone_player with hand-computed timing expectations.
module tb_note_tone_player;

  localparam int TICK_DIV = 1000;
  localparam int DUR_W    = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       octave;
  logic [3:0]       note;
  logic [DUR_W-1:0] duration;
  logic             busy;
  logic             done;
  logic             speaker;

  int n_vec;
  int n_err;

  note_tone_player #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .octave   (octave),
    .note     (note),
    .duration (duration),
    .busy     (busy),
    .done     (done),
    .speaker  (speaker)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues start, then follows the note sample by sample.
  task automatic run_note(input int o, input int n, input int d, input int half,
                          input int exp_edges, input string tag);
    int idx;
    int edges;
    int done_early;
    logic last_spk;
    start    = 1'b1;
    octave   = 3'(o);
    note     = 4'(n);
    duration = DUR_W'(d);
    @(negedge clk);
    start = 1'b0;
    check_vec({tag, "_busy_rise"}, int'(busy), 1);
    idx = 0;
    edges = 0;
    done_early = 0;
    last_spk = speaker;
    while (idx < d * TICK_DIV + 10) begin
      @(negedge clk);
      idx++;
      if (!busy) break;
      if (done) done_early++;
      if (speaker != last_spk) begin
        edges++;
        check_vec({tag, "_edge_at"}, idx, edges * half);
        last_spk = speaker;
      end
    end
    check_vec({tag, "_busy_len"}, idx, d * TICK_DIV);
    check_vec({tag, "_edges"}, edges, exp_edges);
    check_vec({tag, "_done_early"}, done_early, 0);
    check_vec({tag, "_done"}, int'(done), 1);
    check_vec({tag, "_spk_end"}, int'(speaker), 0);
    @(negedge clk);
    check_vec({tag, "_done_1cyc"}, int'(done), 0);
    check_vec({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int bad;
    int idx;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    octave = '0;
    note = '0;
    duration = '0;

    // Start held during reset must do nothing.
    repeat (3) @(negedge clk);
    start = 1'b1;
    duration = 8'd5;
    repeat (3) @(negedge clk);
    check_vec("rst_busy", int'(busy), 0);
    check_vec("rst_done", int'(done), 0);
    check_vec("rst_spk", int'(speaker), 0);
    start = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done || speaker) bad++;
    end
    check_vec("quiet_after_rst", bad, 0);

    // octave 7 note 0: (511+1)*(1+1)=1024
    run_note(7, 0, 3, 1024, 2, "o7n0");
    // octave 5 note 11: 271*8=2168, 9999/2168 -> 4 edges
    run_note(5, 11, 10, 2168, 4, "o5n11");
    // rest
    run_note(0, 13, 2, 1, 0, "rest");

    // zero duration: done only, then back-to-back start on the done cycle
    @(negedge clk);
    start = 1'b1;
    octave = 3'd2;
    note = 4'd4;
    duration = '0;
    @(negedge clk);
    start = 1'b0;
    check_vec("dur0_done", int'(done), 1);
    check_vec("dur0_busy", int'(busy), 0);
    check_vec("dur0_spk", int'(speaker), 0);
    // octave 6 note 9: 304*4=1216, 2999/1216 -> 2 edges
    run_note(6, 9, 3, 1216, 2, "b2b");

    // Mid-note: ignored second start, then asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    octave = 3'd7;
    note = 4'd0;
    duration = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check_vec("mid_busy", int'(busy), 1);
    idx = 0;
    bad = 0;
    while (idx < 1500) begin
      @(negedge clk);
      idx++;
      if (idx == 500) begin
        start = 1'b1;
        octave = 3'd0;
        note = 4'd11;
        duration = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (speaker && bad == 0) begin
        bad = 1;
        check_vec("mid_first_edge", idx, 1024);
      end
    end
    check_vec("mid_toggled", bad, 1);
    check_vec("mid_still_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_busy", int'(busy), 0);
    check_vec("async_spk", int'(speaker), 0);
    check_vec("async_done", int'(done), 0);
    @(negedge clk);
    check_vec("rst_no_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("post_rst_done", int'(done), 0);
    // octave 7 note 5: 384*2=768, 3999/768 -> 5 edges
    run_note(7, 5, 4, 768, 5, "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
